// File: rtl/ghost_mover.sv
// ghost_mover: one-per-ghost motion executor. It validates the requested direction against
// the wall flags of the current tile, counts movement ticks, and then advances one tile.
// Position and heading are owned here and fed back to the behaviour and render logic.
module ghost_mover #(
    parameter int unsigned X_WIDTH        = 5,
    parameter int unsigned Y_WIDTH        = 5,
    parameter int unsigned MAP_W          = 28,
    parameter int unsigned START_X        = 13,
    parameter int unsigned START_Y        = 11,
    parameter int unsigned TICKS_PER_STEP = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               tick,
    input  logic               respawn,
    input  logic [1:0]         dirToMove,
    input  logic               canMoveU,
    input  logic               canMoveR,
    input  logic               canMoveD,
    input  logic               canMoveL,
    output logic [X_WIDTH-1:0] ghostPosX,
    output logic [Y_WIDTH-1:0] ghostPosY,
    output logic [1:0]         ghostDir,
    output logic               moving,
    output logic               stepDone
);

    localparam int unsigned CNT_W = $clog2(TICKS_PER_STEP + 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [X_WIDTH-1:0] X_SPAWN = X_WIDTH'(START_X);
    localparam logic [Y_WIDTH-1:0] Y_SPAWN = Y_WIDTH'(START_Y);
    localparam logic [X_WIDTH-1:0] X_LAST  = X_WIDTH'(MAP_W - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST  = '1;
    localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(TICKS_PER_STEP - 1);

    // Decide is split in two cycles so a 1-cycle-latency maze ROM has settled the flags
    // for the new tile before they are sampled in StDecideB.
    typedef enum logic [2:0] {
        StIdle,
        StDecideA,
        StDecideB,
        StWait,
        StStep
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_WIDTH-1:0] pos_x_q, pos_x_d;
    logic [Y_WIDTH-1:0] pos_y_q, pos_y_d;
    logic [1:0]         dir_q, dir_d;
    logic               step_done_q, step_done_d;
    logic [3:0]         can_move;

    // Wall flags indexed by direction code.
    assign can_move = {canMoveL, canMoveD, canMoveR, canMoveU};

    // Next-state logic: respawn beats enable, enable beats normal sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_d       = dir_q;
        step_done_d = 1'b0;

        if (respawn) begin
            state_d = StIdle;
            cnt_d   = '0;
            pos_x_d = X_SPAWN;
            pos_y_d = Y_SPAWN;
            dir_d   = DIR_LEFT;
        end else if (enable) begin
            unique case (state_q)
                StIdle:    state_d = StDecideA;
                StDecideA: state_d = StDecideB;
                StDecideB: begin
                    if (can_move[dirToMove]) begin
                        dir_d   = dirToMove;
                        state_d = StWait;
                    end else if (can_move[dir_q]) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (tick) begin
                        if (cnt_q == CNT_TOP) begin
                            cnt_d   = '0;
                            state_d = StStep;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StStep: begin
                    step_done_d = 1'b1;
                    state_d     = StDecideA;
                    unique case (dir_q)
                        DIR_UP:    if (pos_y_q != '0) pos_y_d = pos_y_q - 1'b1;
                        DIR_DOWN:  if (pos_y_q != Y_LAST) pos_y_d = pos_y_q + 1'b1;
                        DIR_RIGHT: pos_x_d = (pos_x_q == X_LAST) ? '0 : pos_x_q + 1'b1;
                        DIR_LEFT:  pos_x_d = (pos_x_q == '0) ? X_LAST : pos_x_q - 1'b1;
                        default:   ;
                    endcase
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pos_x_q     <= X_SPAWN;
            pos_y_q     <= Y_SPAWN;
            dir_q       <= DIR_LEFT;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            step_done_q <= step_done_d;
        end
    end

    assign ghostPosX = pos_x_q;
    assign ghostPosY = pos_y_q;
    assign ghostDir  = dir_q;
    assign moving    = (state_q == StWait);
    assign stepDone  = step_done_q;

endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover: randomized walk of one ghost against a tile-level reference model.
module tb_ghost_mover;

    localparam int X_WIDTH = 5;
    localparam int Y_WIDTH = 5;
    localparam int MAP_W   = 28;
    localparam int START_X = 13;
    localparam int START_Y = 11;
    localparam int TPS     = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               tick;
    logic               respawn;
    logic [1:0]         dirToMove;
    logic               canMoveU, canMoveR, canMoveD, canMoveL;
    logic [X_WIDTH-1:0] ghostPosX;
    logic [Y_WIDTH-1:0] ghostPosY;
    logic [1:0]         ghostDir;
    logic               moving;
    logic               stepDone;

    int checks = 0;
    int errors = 0;
    int m_x, m_y, m_dir;

    ghost_mover #(
        .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .MAP_W(MAP_W),
        .START_X(START_X), .START_Y(START_Y), .TICKS_PER_STEP(TPS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick), .respawn(respawn),
        .dirToMove(dirToMove), .canMoveU(canMoveU), .canMoveR(canMoveR),
        .canMoveD(canMoveD), .canMoveL(canMoveL), .ghostPosX(ghostPosX),
        .ghostPosY(ghostPosY), .ghostDir(ghostDir), .moving(moving), .stepDone(stepDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Tile-level move: X is a torus of MAP_W tiles, Y is clamped to the coordinate range.
    function automatic void model_move(input int d);
        case (d)
            0: if (m_y > 0) m_y--;
            1: m_x = (m_x + 1) % MAP_W;
            2: if (m_y < (1 << Y_WIDTH) - 1) m_y++;
            default: m_x = (m_x + MAP_W - 1) % MAP_W;
        endcase
    endfunction

    function automatic void model_spawn();
        m_x   = START_X;
        m_y   = START_Y;
        m_dir = 3;
    endfunction

    task automatic check_pos(input string tag);
        check({tag, "_x"}, int'(ghostPosX), m_x);
        check({tag, "_y"}, int'(ghostPosY), m_y);
        check({tag, "_dir"}, int'(ghostDir), m_dir);
    endtask

    // One tile attempt. fl bits are U,R,D,L at indices 0..3.
    task automatic do_step(input logic [1:0] req, input logic [3:0] fl,
                           input bit freeze, input bit resp);
        int nd;
        int stray;
        int n;
        dirToMove = req;
        {canMoveL, canMoveD, canMoveR, canMoveU} = fl;
        if (fl[req]) nd = req;
        else if (fl[m_dir]) nd = m_dir;
        else nd = -1;
        stray = 0;

        if (nd < 0) begin
            for (int t = 0; t < 20; t++) begin
                tick = 1'b1;
                cyc();
                tick = 1'b0;
                stray += int'(stepDone) + int'(moving);
                for (int g = 0; g < 3; g++) begin
                    cyc();
                    stray += int'(stepDone) + int'(moving);
                end
            end
            check("blocked_activity", stray, 0);
            check_pos("blocked");
            return;
        end

        n = 0;
        while (!moving && n < 10) begin
            cyc();
            stray += int'(stepDone);
            n++;
        end
        check("enter_wait", int'(moving), 1);
        check("heading", int'(ghostDir), nd);
        m_dir = nd;

        for (int t = 1; t <= TPS; t++) begin
            int gap;
            gap = $urandom_range(3, 5);
            for (int g = 0; g < gap; g++) begin
                cyc();
                stray += int'(stepDone);
            end
            if (freeze && t == 5) begin
                int fz;
                fz = 0;
                enable = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick = 1'b1;
                    cyc();
                    tick = 1'b0;
                    cyc();
                    fz += int'(stepDone) + int'(!moving);
                end
                check("freeze_activity", fz, 0);
                check_pos("freeze");
                enable = 1'b1;
            end
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            stray += int'(stepDone);
        end
        check("early_step", stray, 0);

        if (resp) begin
            respawn = 1'b1;
            cyc();
            respawn = 1'b0;
            model_spawn();
            check("respawn_stepdone", int'(stepDone), 0);
            check("respawn_moving", int'(moving), 0);
            check_pos("respawn");
            return;
        end

        cyc();
        model_move(m_dir);
        check("step_pulse", int'(stepDone), 1);
        check_pos("step");
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        tick      = 1'b0;
        respawn   = 1'b0;
        dirToMove = 2'b00;
        {canMoveL, canMoveD, canMoveR, canMoveU} = 4'hF;
        model_spawn();
        repeat (3) cyc();
        check("rst_moving", int'(moving), 0);
        check("rst_stepdone", int'(stepDone), 0);
        check_pos("rst");
        reset  = 1'b1;
        enable = 1'b1;

        // Right from spawn, then left back, then blocked request falls back to heading.
        do_step(2'b01, 4'hF, 1'b0, 1'b0);
        do_step(2'b11, 4'hF, 1'b0, 1'b0);
        do_step(2'b00, 4'b1000, 1'b0, 1'b0);

        // Fully walled in, then an opening downward.
        do_step(2'b00, 4'h0, 1'b0, 1'b0);
        do_step(2'b10, 4'b0100, 1'b0, 1'b0);

        // Walk left to the tunnel, wrap to MAP_W-1, then wrap back right.
        while (m_x > 0) do_step(2'b11, 4'hF, 1'b0, 1'b0);
        check("at_x0", int'(ghostPosX), 0);
        do_step(2'b11, 4'hF, 1'b0, 1'b0);
        check("wrap_left", int'(ghostPosX), MAP_W - 1);
        do_step(2'b01, 4'hF, 1'b0, 1'b0);
        check("wrap_right", int'(ghostPosX), 0);

        // Freeze mid-wait, then respawn coinciding with STEP.
        do_step(2'b10, 4'hF, 1'b1, 1'b0);
        do_step(2'b10, 4'hF, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] rq;
            logic [3:0] fl;
            rq = 2'($urandom_range(0, 3));
            fl = 4'($urandom_range(0, 15));
            do_step(rq, fl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset in the middle of a wait.
        dirToMove = 2'b01;
        {canMoveL, canMoveD, canMoveR, canMoveU} = 4'hF;
        begin
            int n;
            n = 0;
            while (!moving && n < 10) begin
                cyc();
                n++;
            end
        end
        check("pre_reset_wait", int'(moving), 1);
        for (int t = 0; t < 3; t++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
        #2 reset = 1'b0;
        #1;
        model_spawn();
        check("async_moving", int'(moving), 0);
        check("async_stepdone", int'(stepDone), 0);
        check_pos("async");
        cyc();
        reset = 1'b1;
        // A full TPS ticks must be needed again after reset.
        do_step(2'b01, 4'hF, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
